ddr_burst_capture: RTL and testbench

- Parametrised successor of the 64-bit DDR clock-sync capture stage in the memory interface datapath.
- Captures a DATA_W-bit input on both clock edges (DDR mode) or on two consecutive rising edges (SDR mode), and assembles each pair into a 2*DATA_W word.
- Tags burst boundaries and buffers assembled words in a first-word-fall-through FIFO with a valid/ready output handshake and sticky overflow reporting.

---
 rtl/ddr_burst_capture.sv | 152 +++++++++++++++
 tb/tb_ddr_burst_capture.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_capture.sv
// ddr_burst_capture
//   Captures a DATA_W-bit beat stream and assembles beat pairs into
//   2*DATA_W-bit words. In DDR mode the pair is taken from the rising and
//   the following falling edge. In SDR mode it is taken from two qualified
//   rising edges. Assembled words are tagged with a burst-last flag and
//   buffered in a first-word-fall-through FIFO. The FIFO has a valid/ready
//   output side and a sticky overflow flag.
//
// Ports
//   clk         system clock; both edges are used in DDR mode
//   rst_n       asynchronous active-low reset
//   ddr_mode    1 = DDR pairing, 0 = SDR pairing (quasi-static)
//   wr_en       beat qualifier, sampled on the rising edge
//   data_in     input beat
//   clr_ovf     synchronous clear of the overflow flag
//   out_ready   downstream accept
//   out_valid   FIFO non-empty
//   out_data    head word ({fall, rise} or {second, first}); 0 when empty
//   out_last    head word closes a burst of BURST_LEN words
//   fifo_level  occupied entry count
//   overflow    sticky: an assembled word was dropped because the FIFO was full
module ddr_burst_capture #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ddr_mode,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          clr_ovf,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [2*DATA_W-1:0]           out_data,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  logic [DATA_W-1:0]   rise_q;
  logic [DATA_W-1:0]   fall_q;
  logic [DATA_W-1:0]   lo_q;
  logic                pend;
  logic                half;
  logic                mode_q;
  logic [CNT_W-1:0]    beat_cnt;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                ovf_q;
  logic [2*DATA_W:0]   mem [FIFO_DEPTH];

  logic                mode_chg;
  logic                asm_vld;
  logic [2*DATA_W-1:0] asm_word;
  logic                asm_last;
  logic                pop;
  logic                push;
  logic                drop;
  logic [2*DATA_W:0]   head;

  // A mode change abandons any partial pair and suppresses assembly that cycle.
  always_comb begin
    mode_chg = (ddr_mode != mode_q);
    asm_vld  = 1'b0;
    asm_word = '0;
    if (!mode_chg) begin
      if (mode_q) begin
        asm_vld  = pend;
        asm_word = {fall_q, rise_q};
      end else if (wr_en && half) begin
        asm_vld  = 1'b1;
        asm_word = {data_in, lo_q};
      end
    end
    asm_last = (beat_cnt == LAST_CNT);
    pop      = (level != '0) && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push     = asm_vld && ((level != FULL_LVL) || pop);
    drop     = asm_vld && !push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q   <= '0;
      lo_q     <= '0;
      pend     <= 1'b0;
      half     <= 1'b0;
      mode_q   <= 1'b0;
      beat_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mode_q <= ddr_mode;
      if (mode_chg) begin
        pend <= 1'b0;
        half <= 1'b0;
      end else if (mode_q) begin
        pend <= wr_en;
        if (wr_en) rise_q <= data_in;
      end else if (wr_en) begin
        if (half) begin
          half <= 1'b0;
        end else begin
          lo_q <= data_in;
          half <= 1'b1;
        end
      end

      // Dropped words still advance the burst position.
      if (asm_vld) beat_cnt <= asm_last ? '0 : beat_cnt + 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  // Falling-edge half of a DDR pair.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)    fall_q <= '0;
    else if (pend) fall_q <= data_in;
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {asm_last, asm_word};
  end

  always_comb begin
    head       = mem[rd_ptr];
    out_valid  = (level != '0);
    out_data   = out_valid ? head[2*DATA_W-1:0] : '0;
    out_last   = out_valid ? head[2*DATA_W] : 1'b0;
    fifo_level = level;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_ddr_burst_capture.sv
// tb_ddr_burst_capture
//   Scenario bench for ddr_burst_capture (DATA_W=64, BURST_LEN=8,
//   FIFO_DEPTH=4) with a queue-based reference model of pairing, burst
//   tagging and FIFO occupancy.
module tb_ddr_burst_capture;

  localparam int DW = 64;
  localparam int BL = 8;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ddr_mode = 1'b0;
  logic            wr_en = 1'b0;
  logic [DW-1:0]   data_in = '0;
  logic            clr_ovf = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [2*DW-1:0] out_data;
  logic            out_last;
  logic [2:0]      fifo_level;
  logic            overflow;

  ddr_burst_capture #(.DATA_W(DW), .BURST_LEN(BL), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .ddr_mode(ddr_mode), .wr_en(wr_en),
    .data_in(data_in), .clr_ovf(clr_ovf), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int passes = 0;

  // Reference model state
  typedef struct { logic [2*DW-1:0] w; bit l; } ent_t;
  ent_t          q[$];
  int            nwords;
  bit            movf, mmode, mpend, mhalf;
  logic [DW-1:0] mrise, mfall, mlo;

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [2*DW-1:0] exp_data();
    return (q.size() != 0) ? q[0].w : '0;
  endfunction

  function automatic bit exp_last();
    return (q.size() != 0) ? q[0].l : 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    nwords = 0;
    movf = 0; mmode = 0; mpend = 0; mhalf = 0;
    mrise = '0; mfall = '0; mlo = '0;
  endtask

  // Effect of one rising edge given the inputs presented before it.
  task automatic model_edge(input bit m, input bit w, input logic [DW-1:0] d,
                            input bit rdy, input bit clr);
    bit              asm_v = 0;
    bit              drop = 0;
    bit              pop;
    logic [2*DW-1:0] word = '0;
    ent_t            e;
    pop = (q.size() != 0) && rdy;
    if (m != mmode) begin
      mpend = 0; mhalf = 0;
    end else if (m) begin
      if (mpend) begin asm_v = 1; word = {mfall, mrise}; end
      mpend = w;
      if (w) mrise = d;
    end else if (w) begin
      if (mhalf) begin asm_v = 1; word = {d, mlo}; mhalf = 0; end
      else begin mlo = d; mhalf = 1; end
    end
    mmode = m;
    if (pop) void'(q.pop_front());
    if (asm_v) begin
      e.w = word;
      e.l = ((nwords % BL) == BL - 1);
      nwords++;
      if (q.size() < D) q.push_back(e);
      else drop = 1;
    end
    if (drop) movf = 1;
    else if (clr) movf = 0;
  endtask

  // One clock cycle: r is presented for the rising edge, f for the falling edge.
  // Entered and left just after a falling edge.
  task automatic step(input bit m, input bit w, input logic [DW-1:0] r,
                      input logic [DW-1:0] f, input bit rdy, input bit clr);
    ddr_mode = m; wr_en = w; data_in = r; out_ready = rdy; clr_ovf = clr;
    model_edge(m, w, r, rdy, clr);
    @(posedge clk); #1;
    data_in = f;
    if (mpend) mfall = f;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passes++;
    checks++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last); else passes++;
    checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else passes++;
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ddr_single();
    step(1, 0, '0, '0, 1, 0);
    step(1, 1, 64'hA, 64'hB, 1, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL single_early: got %b want 0", out_valid); else passes++;
    step(1, 0, '0, '0, 1, 0);
    checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passes++;
    checks++; if (out_data !== {64'hB, 64'hA}) $display("FAIL single_data: got %h want %h", out_data, {64'hB, 64'hA}); else passes++;
    checks++; if (fifo_level !== 3'd1) $display("FAIL single_level1: got %0d want 1", fifo_level); else passes++;
    checks++; if (out_last !== exp_last()) $display("FAIL single_last: got %b want %b", out_last, exp_last()); else passes++;
    step(1, 0, '0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL single_gone: got %b want 0", out_valid); else passes++;
    checks++; if (fifo_level !== 3'd0) $display("FAIL single_level0: got %0d want 0", fifo_level); else passes++;
  endtask

  task automatic test_sdr_gap();
    step(0, 0, '0, '0, 0, 0);
    step(0, 1, 64'd1, '0, 0, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL sdr_half: got %b want 0", out_valid); else passes++;
    step(0, 1, 64'd2, '0, 0, 0);
    checks++; if (out_data !== {64'd2, 64'd1}) $display("FAIL sdr_word0: got %h want %h", out_data, {64'd2, 64'd1}); else passes++;
    step(0, 0, 64'd99, '0, 0, 0);
    step(0, 1, 64'd3, '0, 0, 0);
    checks++; if (out_data !== {64'd2, 64'd1}) $display("FAIL sdr_hold: got %h want %h", out_data, {64'd2, 64'd1}); else passes++;
    step(0, 1, 64'd4, '0, 0, 0);
    checks++; if (fifo_level !== 3'd2) $display("FAIL sdr_level: got %0d want 2", fifo_level); else passes++;
    checks++; if (out_last !== exp_last()) $display("FAIL sdr_last0: got %b want %b", out_last, exp_last()); else passes++;
    step(0, 0, '0, '0, 1, 0);
    checks++; if (out_data !== {64'd4, 64'd3}) $display("FAIL sdr_word1: got %h want %h", out_data, {64'd4, 64'd3}); else passes++;
    checks++; if (out_last !== exp_last()) $display("FAIL sdr_last1: got %b want %b", out_last, exp_last()); else passes++;
    step(0, 0, '0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL sdr_empty: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_overflow();
    do_reset();
    step(1, 0, '0, '0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, rnd64(), rnd64(), 0, 0);
    step(1, 0, '0, '0, 0, 0);
    checks++; if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d want 4", fifo_level); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp_data()) $display("FAIL ovf_drain%0d: got %h want %h", i, out_data, exp_data()); else passes++;
      step(1, 0, '0, '0, 1, 0);
    end
    checks++; if (fifo_level !== 3'd0) $display("FAIL ovf_drained: got %0d want 0", fifo_level); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passes++;
    step(1, 0, '0, '0, 0, 1);
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else passes++;
    step(1, 1, rnd64(), rnd64(), 0, 0);
    step(1, 1, rnd64(), rnd64(), 0, 0);
    step(1, 0, '0, '0, 0, 0);
    checks++; if (out_last !== 1'b0) $display("FAIL ovf_word6_last: got %b want 0", out_last); else passes++;
    step(1, 0, '0, '0, 1, 0);
    checks++; if (out_last !== 1'b1) $display("FAIL ovf_word7_last: got %b want 1", out_last); else passes++;
    checks++; if (out_data !== exp_data()) $display("FAIL ovf_word7_data: got %h want %h", out_data, exp_data()); else passes++;
    step(1, 0, '0, '0, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) step(1, 1, rnd64(), rnd64(), 0, 0);
    checks++; if (fifo_level !== 3'd4) $display("FAIL b2b_fill: got %0d want 4", fifo_level); else passes++;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, rnd64(), rnd64(), 1, 0);
      checks++; if (fifo_level !== 3'd4) $display("FAIL b2b_level%0d: got %0d want 4", i, fifo_level); else passes++;
      checks++; if (overflow !== 1'b0) $display("FAIL b2b_ovf%0d: got %b want 0", i, overflow); else passes++;
      checks++; if (out_data !== exp_data()) $display("FAIL b2b_data%0d: got %h want %h", i, out_data, exp_data()); else passes++;
    end
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_last !== exp_last()) $display("FAIL b2b_drain_last%0d: got %b want %b", i, out_last, exp_last()); else passes++;
      step(1, 0, '0, '0, 1, 0);
    end
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_mode_switch();
    logic [DW-1:0] a, b;
    a = rnd64(); b = rnd64();
    step(0, 0, '0, '0, 1, 0);
    step(0, 1, rnd64(), '0, 1, 0);
    step(1, 1, rnd64(), rnd64(), 1, 0);
    checks++; if (fifo_level !== 3'd0) $display("FAIL switch_nopush: got %0d want 0", fifo_level); else passes++;
    step(1, 0, '0, '0, 1, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL switch_ignored: got %b want 0", out_valid); else passes++;
    step(1, 1, a, b, 1, 0);
    step(1, 0, '0, '0, 1, 0);
    checks++; if (out_data !== {b, a}) $display("FAIL switch_pair: got %h want %h", out_data, {b, a}); else passes++;
    step(1, 0, '0, '0, 1, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1, 1, rnd64(), rnd64(), 0, 0);
    checks++; if (fifo_level !== 3'd3) $display("FAIL mid_prelevel: got %0d want 3", fifo_level); else passes++;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", out_valid); else passes++;
    checks++; if (out_data !== '0) $display("FAIL mid_data: got %h want 0", out_data); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL mid_last: got %b want 0", out_last); else passes++;
    checks++; if (fifo_level !== 3'd0) $display("FAIL mid_level: got %0d want 0", fifo_level); else passes++;
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(1, 0, '0, '0, 1, 0);
    for (int i = 0; i < BL; i++) step(1, 1, rnd64(), rnd64(), 1, 0);
    step(1, 0, '0, '0, 1, 0);
    checks++; if (out_last !== 1'b1) $display("FAIL mid_retag_last: got %b want 1", out_last); else passes++;
    checks++; if (out_data !== exp_data()) $display("FAIL mid_retag_data: got %h want %h", out_data, exp_data()); else passes++;
    step(1, 0, '0, '0, 1, 0);
  endtask

  task automatic test_random();
    bit m;
    m = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(39) == 0) m = ~m;
      step(m, ($urandom_range(9) < 7), rnd64(), rnd64(),
           ($urandom_range(9) < 6), ($urandom_range(19) == 0));
      checks++; if (out_valid !== (q.size() != 0)) $display("FAIL rnd_valid@%0d: got %b want %b", i, out_valid, (q.size() != 0)); else passes++;
      checks++; if (fifo_level !== 3'(q.size())) $display("FAIL rnd_level@%0d: got %0d want %0d", i, fifo_level, q.size()); else passes++;
      checks++; if (out_data !== exp_data()) $display("FAIL rnd_data@%0d: got %h want %h", i, out_data, exp_data()); else passes++;
      checks++; if (out_last !== exp_last()) $display("FAIL rnd_last@%0d: got %b want %b", i, out_last, exp_last()); else passes++;
      checks++; if (overflow !== movf) $display("FAIL rnd_ovf@%0d: got %b want %b", i, overflow, movf); else passes++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ddr_single();
    test_sdr_gap();
    test_overflow();
    test_back_to_back();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
